int_ctl: RTL and testbench
==========================

Name: int_ctl

Overview:
- Parametrised interrupt/reset sequencer for the 65C02 core.
- Synchronises NIRQ maskable request lines plus NMI, selectable per line as level- or edge-sensitive, and latches NMI edges.
- Arbitrates reset > NMI > IRQ and commits a single source at an instruction boundary (sync).
- Presents the frozen vector address to the microcode sequencer until the vector fetch is acknowledged. Supports the legacy 3-vector map and an extended per-line vector table.

Parameters:
- NIRQ, 4: number of maskable request lines (1..16).
- SYNC_STAGES, 2: input synchroniser depth (1..3).
- EDGE_MASK, 0: NIRQ-bit mask; bit k=1 makes IRQ[k] rising-edge-latched, 0 makes it level-sensitive.
- EXT_VEC, 0: 0 = every IRQ uses FFFE; 1 = IRQ[k] uses VEC_BASE+2k.
- VEC_BASE, 16'hFFE0: base address of the extended IRQ vector table.

Ports:
- clk  in  1  CPU clock.
- RST  in  1  asynchronous, active-low reset.
- IRQ  in  NIRQ  asynchronous maskable requests, active high.
- NMI  in  1  asynchronous non-maskable request, rising-edge-triggered.
- I  in  1  CPU interrupt-disable flag.
- sync  in  1  instruction boundary strobe from ctl.
- ack  in  1  vector fetch done; releases the committed source.
- mask_we  in  1  write strobe for the per-line mask register.
- mask_wd  in  NIRQ  mask write data (1 = line masked).
- int_pend  out  1  an eligible source exists (registered).
- int_take  out  1  a source is committed; ctl must enter the vector sequence.
- VEC  out  16  vector address of the committed source.
- src  out  4  committed IRQ index (0 when NMI or reset is committed).
- is_nmi  out  1  committed source is NMI.
- is_rst  out  1  committed source is reset.
- mask  out  NIRQ  current mask register.

Behaviour:
- Reset, while RST=0 (async):
  - state=RESET; all latches, synchronisers and the previous-NMI flop cleared.
  - mask = all ones.
  - int_take=1, is_rst=1, is_nmi=0, src=0, VEC=16'hFFFC, int_pend=0.
- Synchronisers: IRQ and NMI each pass through SYNC_STAGES flops. "sIRQ" and "sNMI" denote the synchronised values.
- NMI latch:
  - Set when sNMI=1 and the previous sNMI=0.
  - Cleared in the cycle ack=1 while is_nmi=1.
  - A set and a clear in the same cycle leave it set: the new edge wins.
- IRQ pending:
  - Edge line: latch set on a rising edge of sIRQ[k]; cleared on ack with src=k and is_rst=0 and is_nmi=0. Set wins over clear.
  - Level line: pending = sIRQ[k]; no latch.
  - Eligible IRQ[k] = pending[k] & ~mask[k] & ~I.
  - The mask gates eligibility only; an edge latch still captures edges on a masked line.
- Arbitration: NMI latch > lowest-index eligible IRQ.
- int_pend is registered: it goes high one cycle after eligibility and is independent of state.
- FSM: RESET, IDLE, TAKE.
  - RESET: leaves to IDLE on ack; int_take stays 1 until then.
  - IDLE: when sync=1 and a source is eligible in the same cycle, next state is TAKE. On that clock edge the winner is frozen into VEC, src, is_nmi and is_rst, and int_take becomes 1. sync without an eligible source stays in IDLE.
  - TAKE: outputs are held frozen whatever the inputs do (a level IRQ dropping, I changing, the mask changing, a new NMI). On ack, int_take becomes 0 on the next edge and the state returns to IDLE. A new commit requires a later sync.
  - ack in IDLE is ignored.
- Vectors:
  - NMI: FFFA.
  - Reset: FFFC.
  - IRQ with EXT_VEC=0: FFFE.
  - IRQ with EXT_VEC=1: VEC_BASE + {k,1'b0}, computed as 16-bit and wrapping modulo 2^16.
- mask_we: mask <= mask_wd on the next edge, in any state except while RST=0.
- Latency from an IRQ pin edge to int_pend is SYNC_STAGES+1 cycles.
- RST asserted mid-TAKE: immediate async return to RESET; any pending NMI is lost.

Test Plan:
- Reset release with ack after 3 cycles -> int_take=1 and VEC=FFFC throughout; IDLE after ack; int_take=0; mask=all ones.
- mask_wd=4'b0000; IRQ[2] level high; I=0; sync pulse -> int_pend after 3 cycles; int_take next edge after sync; src=2; VEC=FFFE. Same with EXT_VEC=1 -> VEC=FFE4.
- IRQ[1] and IRQ[3] high, NMI rising edge, same sync -> is_nmi=1, VEC=FFFA. After ack and the next sync -> src=1.
- EDGE_MASK=4'b0001; IRQ[0] pulsed for 1 cycle while I=1 -> no take. Drop I to 0 and pulse sync -> take with src=0. ack -> latch cleared; the next sync does not take.
- In TAKE, drop level IRQ[2] and toggle I -> VEC and src unchanged until ack. A second NMI edge coinciding with the NMI ack -> NMI re-taken at the next sync.
- Pull RST low mid-TAKE -> int_take=1, is_rst=1, VEC=FFFC asynchronously; NMI latch cleared.

Source files
------------

// File: rtl/int_ctl_if.sv
// rtl/int_ctl_if.sv - request/commit bundle between the interrupt sequencer and the CPU control.
interface int_ctl_if #(
    parameter int NIRQ = 4
);
    logic [NIRQ-1:0] IRQ;
    logic            NMI;
    logic            I;
    logic            sync;
    logic            ack;
    logic            mask_we;
    logic [NIRQ-1:0] mask_wd;
    logic            int_pend;
    logic            int_take;
    logic [15:0]     VEC;
    logic [3:0]      src;
    logic            is_nmi;
    logic            is_rst;
    logic [NIRQ-1:0] mask;

    modport master (
        output IRQ, NMI, I, sync, ack, mask_we, mask_wd,
        input  int_pend, int_take, VEC, src, is_nmi, is_rst, mask
    );

    modport slave (
        input  IRQ, NMI, I, sync, ack, mask_we, mask_wd,
        output int_pend, int_take, VEC, src, is_nmi, is_rst, mask
    );
endinterface

// File: rtl/int_ctl.sv
// rtl/int_ctl.sv - reset/NMI/IRQ sequencer that commits one source per instruction boundary.
module int_ctl #(
    parameter int              NIRQ        = 4,
    parameter int              SYNC_STAGES = 2,
    parameter logic [NIRQ-1:0] EDGE_MASK   = '0,
    parameter int              EXT_VEC     = 0,
    parameter logic [15:0]     VEC_BASE    = 16'hFFE0
) (
    input  logic      clk,
    input  logic      RST,
    int_ctl_if.slave  bus
);
    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_TAKE  = 2'd2;

    logic [SYNC_STAGES-1:0][NIRQ-1:0] irq_sync_q, irq_sync_d;
    logic [SYNC_STAGES-1:0]           nmi_sync_q, nmi_sync_d;
    logic [NIRQ-1:0] irq_prev_q, irq_prev_d;
    logic [NIRQ-1:0] irq_lat_q, irq_lat_d;
    logic [NIRQ-1:0] mask_q, mask_d;
    logic            nmi_prev_q, nmi_prev_d;
    logic            nmi_lat_q, nmi_lat_d;
    logic            pend_q, pend_d;
    logic [1:0]      state_q, state_d;
    logic [15:0]     vec_q, vec_d;
    logic [3:0]      src_q, src_d;
    logic            is_nmi_q, is_nmi_d;
    logic            is_rst_q, is_rst_d;

    logic [NIRQ-1:0] s_irq, pending, eligible, irq_clr;
    logic            s_nmi, any_elig, ack_take;
    logic [3:0]      irq_idx;

    always_comb begin
        irq_sync_d    = irq_sync_q;
        nmi_sync_d    = nmi_sync_q;
        irq_sync_d[0] = bus.IRQ;
        nmi_sync_d[0] = bus.NMI;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            irq_sync_d[i] = irq_sync_q[i-1];
            nmi_sync_d[i] = nmi_sync_q[i-1];
        end
    end

    assign s_irq    = irq_sync_q[SYNC_STAGES-1];
    assign s_nmi    = nmi_sync_q[SYNC_STAGES-1];
    assign ack_take = bus.ack && (state_q == ST_TAKE);

    always_comb begin
        irq_clr = '0;
        for (int k = 0; k < NIRQ; k++)
            irq_clr[k] = ack_take && !is_nmi_q && !is_rst_q && (src_q == 4'(k));
    end

    // Set terms are OR-ed after the clear so a coincident new edge survives the ack.
    assign irq_lat_d  = EDGE_MASK & ((s_irq & ~irq_prev_q) | (irq_lat_q & ~irq_clr));
    assign nmi_lat_d  = (s_nmi && !nmi_prev_q) || (nmi_lat_q && !(ack_take && is_nmi_q));
    assign irq_prev_d = s_irq;
    assign nmi_prev_d = s_nmi;

    assign pending  = (EDGE_MASK & irq_lat_q) | (~EDGE_MASK & s_irq);
    assign eligible = pending & ~mask_q & {NIRQ{~bus.I}};
    assign any_elig = nmi_lat_q || (|eligible);
    assign pend_d   = any_elig;
    assign mask_d   = bus.mask_we ? bus.mask_wd : mask_q;

    always_comb begin
        irq_idx = '0;
        for (int k = NIRQ - 1; k >= 0; k--)
            if (eligible[k]) irq_idx = 4'(k);
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        src_d    = src_q;
        is_nmi_d = is_nmi_q;
        is_rst_d = is_rst_q;
        case (state_q)
            ST_RESET: if (bus.ack) state_d = ST_IDLE;
            ST_IDLE: begin
                if (bus.sync && any_elig) begin
                    state_d  = ST_TAKE;
                    is_rst_d = 1'b0;
                    if (nmi_lat_q) begin
                        is_nmi_d = 1'b1;
                        src_d    = 4'd0;
                        vec_d    = 16'hFFFA;
                    end else begin
                        is_nmi_d = 1'b0;
                        src_d    = irq_idx;
                        vec_d    = (EXT_VEC != 0) ? VEC_BASE + 16'({irq_idx, 1'b0}) : 16'hFFFE;
                    end
                end
            end
            ST_TAKE: if (bus.ack) state_d = ST_IDLE;
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            irq_sync_q <= '0;
            nmi_sync_q <= '0;
            irq_prev_q <= '0;
            nmi_prev_q <= 1'b0;
            irq_lat_q  <= '0;
            nmi_lat_q  <= 1'b0;
            mask_q     <= '1;
            pend_q     <= 1'b0;
            state_q    <= ST_RESET;
            vec_q      <= 16'hFFFC;
            src_q      <= 4'd0;
            is_nmi_q   <= 1'b0;
            is_rst_q   <= 1'b1;
        end else begin
            irq_sync_q <= irq_sync_d;
            nmi_sync_q <= nmi_sync_d;
            irq_prev_q <= irq_prev_d;
            nmi_prev_q <= nmi_prev_d;
            irq_lat_q  <= irq_lat_d;
            nmi_lat_q  <= nmi_lat_d;
            mask_q     <= mask_d;
            pend_q     <= pend_d;
            state_q    <= state_d;
            vec_q      <= vec_d;
            src_q      <= src_d;
            is_nmi_q   <= is_nmi_d;
            is_rst_q   <= is_rst_d;
        end
    end

    assign bus.int_pend = pend_q;
    assign bus.int_take = (state_q != ST_IDLE);
    assign bus.VEC      = vec_q;
    assign bus.src      = src_q;
    assign bus.is_nmi   = is_nmi_q;
    assign bus.is_rst   = is_rst_q;
    assign bus.mask     = mask_q;
endmodule

// File: tb/tb_int_ctl.sv
// tb/tb_int_ctl.sv - directed and randomized checks of int_ctl against a behavioural model.
module tb_int_ctl;
    localparam int         SS   = 2;
    localparam logic [3:0] EDGE = 4'b0001;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] irq = '0, mask_wd = '0;
    logic       nmi = 1'b0, i_flag = 1'b0, sync = 1'b0, ack = 1'b0, mask_we = 1'b0;
    int         n_checks = 0, n_errors = 0;

    int_ctl_if #(.NIRQ(4)) bus1 ();
    int_ctl_if #(.NIRQ(4)) bus0 ();

    assign bus1.IRQ = irq;      assign bus0.IRQ = irq;
    assign bus1.NMI = nmi;      assign bus0.NMI = nmi;
    assign bus1.I = i_flag;     assign bus0.I = i_flag;
    assign bus1.sync = sync;    assign bus0.sync = sync;
    assign bus1.ack = ack;      assign bus0.ack = ack;
    assign bus1.mask_we = mask_we; assign bus0.mask_we = mask_we;
    assign bus1.mask_wd = mask_wd; assign bus0.mask_wd = mask_wd;

    int_ctl #(.NIRQ(4), .SYNC_STAGES(SS), .EDGE_MASK(EDGE), .EXT_VEC(1), .VEC_BASE(16'hFFE0))
        dut (.clk(clk), .RST(RST), .bus(bus1));
    int_ctl #(.NIRQ(4), .SYNC_STAGES(SS), .EDGE_MASK(4'b0000), .EXT_VEC(0), .VEC_BASE(16'hFFE0))
        dut_legacy (.clk(clk), .RST(RST), .bus(bus0));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: synchroniser as a delay queue, pending sources as flags.
    bit [3:0]  m_irq_q[$];
    bit        m_nmi_q[$];
    bit [3:0]  m_prev, m_lat, m_mask;
    bit        m_prev_nmi, m_nmi_lat, m_pend, m_take, m_is_nmi, m_is_rst;
    bit [3:0]  m_src;
    bit [15:0] m_vec;

    task automatic model_reset();
        m_irq_q = {};
        m_nmi_q = {};
        for (int i = 0; i < SS; i++) begin
            m_irq_q.push_back(4'b0);
            m_nmi_q.push_back(1'b0);
        end
        m_prev = '0; m_lat = '0; m_mask = 4'hF;
        m_prev_nmi = 0; m_nmi_lat = 0; m_pend = 0;
        m_take = 1; m_is_rst = 1; m_is_nmi = 0; m_src = 0; m_vec = 16'hFFFC;
    endtask

    task automatic model_step();
        bit [3:0] s, pend, elig, lat_n;
        bit       sn, any, nmi_n;
        int       win;
        s  = m_irq_q[SS-1];
        sn = m_nmi_q[SS-1];
        for (int k = 0; k < 4; k++) pend[k] = EDGE[k] ? m_lat[k] : s[k];
        elig  = pend & ~m_mask & {4{~i_flag}};
        any   = m_nmi_lat || (elig != 0);
        lat_n = m_lat;
        nmi_n = m_nmi_lat;
        if (m_take && ack) begin
            if (m_is_nmi) nmi_n = 0;
            else if (!m_is_rst) lat_n[m_src] = 0;
            m_take = 0;
        end else if (!m_take && sync && any) begin
            m_take = 1;
            m_is_rst = 0;
            if (m_nmi_lat) begin
                m_is_nmi = 1; m_src = 0; m_vec = 16'hFFFA;
            end else begin
                win = -1;
                for (int k = 0; k < 4; k++) if (win < 0 && elig[k]) win = k;
                m_is_nmi = 0; m_src = 4'(win); m_vec = 16'hFFE0 + 16'(2 * win);
            end
        end
        if (sn && !m_prev_nmi) nmi_n = 1;
        for (int k = 0; k < 4; k++) if (EDGE[k] && s[k] && !m_prev[k]) lat_n[k] = 1;
        m_lat = lat_n; m_nmi_lat = nmi_n;
        m_prev = s; m_prev_nmi = sn; m_pend = any;
        if (mask_we) m_mask = mask_wd;
        m_irq_q.push_front(irq);  void'(m_irq_q.pop_back());
        m_nmi_q.push_front(nmi);  void'(m_nmi_q.pop_back());
    endtask

    always @(posedge clk or negedge RST) begin
        if (!RST) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        check("m_int_take", {31'b0, bus1.int_take}, {31'b0, m_take});
        check("m_int_pend", {31'b0, bus1.int_pend}, {31'b0, m_pend});
        check("m_mask", {28'b0, bus1.mask}, {28'b0, m_mask});
        if (m_take) begin
            check("m_vec", {16'b0, bus1.VEC}, {16'b0, m_vec});
            check("m_src", {28'b0, bus1.src}, {28'b0, m_src});
            check("m_is_nmi", {31'b0, bus1.is_nmi}, {31'b0, m_is_nmi});
            check("m_is_rst", {31'b0, bus1.is_rst}, {31'b0, m_is_rst});
        end
    end

    task automatic pulse_sync();
        sync = 1; tick(); sync = 0;
    endtask

    task automatic pulse_ack();
        ack = 1; tick(); ack = 0;
    endtask

    initial begin
        #2 RST = 0;
        #1;
        check("rst_take", {31'b0, bus1.int_take}, 32'd1);
        check("rst_is_rst", {31'b0, bus1.is_rst}, 32'd1);
        check("rst_vec", {16'b0, bus1.VEC}, 32'hFFFC);
        check("rst_pend", {31'b0, bus1.int_pend}, 32'd0);
        check("rst_mask", {28'b0, bus1.mask}, 32'hF);
        repeat (2) tick();
        RST = 1;
        repeat (3) tick();
        check("rst_hold_take", {31'b0, bus1.int_take}, 32'd1);
        check("rst_hold_vec", {16'b0, bus1.VEC}, 32'hFFFC);
        pulse_ack();
        check("rst_ack_take", {31'b0, bus1.int_take}, 32'd0);
        check("rst_ack_mask", {28'b0, bus1.mask}, 32'hF);

        mask_we = 1; mask_wd = 4'b0000; tick(); mask_we = 0;
        check("mask_wr", {28'b0, bus1.mask}, 32'h0);
        irq = 4'b0100;
        repeat (2) tick();
        check("pend_early", {31'b0, bus1.int_pend}, 32'd0);
        tick();
        check("pend_lat", {31'b0, bus1.int_pend}, 32'd1);
        pulse_sync();
        check("lvl_take", {31'b0, bus1.int_take}, 32'd1);
        check("lvl_src", {28'b0, bus1.src}, 32'd2);
        check("lvl_vec_ext", {16'b0, bus1.VEC}, 32'hFFE4);
        check("lvl_vec_legacy", {16'b0, bus0.VEC}, 32'hFFFE);
        check("lvl_src_legacy", {28'b0, bus0.src}, 32'd2);
        irq = 4'b0000; i_flag = 1;
        tick(); i_flag = 0; tick(); i_flag = 1; tick();
        check("frz_vec", {16'b0, bus1.VEC}, 32'hFFE4);
        check("frz_src", {28'b0, bus1.src}, 32'd2);
        check("frz_take", {31'b0, bus1.int_take}, 32'd1);
        pulse_ack();
        i_flag = 0;
        check("lvl_rel", {31'b0, bus1.int_take}, 32'd0);

        irq = 4'b1010; nmi = 1;
        repeat (4) tick();
        pulse_sync();
        check("arb_nmi", {31'b0, bus1.is_nmi}, 32'd1);
        check("arb_nmi_vec", {16'b0, bus1.VEC}, 32'hFFFA);
        pulse_ack();
        pulse_sync();
        check("arb_irq_src", {28'b0, bus1.src}, 32'd1);
        check("arb_irq_vec", {16'b0, bus1.VEC}, 32'hFFE2);
        pulse_ack();
        irq = 4'b0000; nmi = 0;

        i_flag = 1;
        irq = 4'b0001; tick(); irq = 4'b0000;
        repeat (5) tick();
        pulse_sync();
        check("edge_masked_i", {31'b0, bus1.int_take}, 32'd0);
        i_flag = 0;
        pulse_sync();
        check("edge_take", {31'b0, bus1.int_take}, 32'd1);
        check("edge_src", {28'b0, bus1.src}, 32'd0);
        check("edge_vec", {16'b0, bus1.VEC}, 32'hFFE0);
        pulse_ack();
        pulse_sync();
        check("edge_cleared", {31'b0, bus1.int_take}, 32'd0);

        nmi = 1; repeat (4) tick();
        pulse_sync();
        check("nmi2_take", {31'b0, bus1.is_nmi}, 32'd1);
        nmi = 0; repeat (4) tick();
        nmi = 1; tick(); tick();
        pulse_ack();
        check("nmi2_rel", {31'b0, bus1.int_take}, 32'd0);
        pulse_sync();
        check("nmi2_retake", {31'b0, bus1.int_take}, 32'd1);
        check("nmi2_is_nmi", {31'b0, bus1.is_nmi}, 32'd1);

        nmi = 0; repeat (4) tick();
        nmi = 1; repeat (4) tick();
        #2 RST = 0;
        #1;
        check("async_take", {31'b0, bus1.int_take}, 32'd1);
        check("async_is_rst", {31'b0, bus1.is_rst}, 32'd1);
        check("async_vec", {16'b0, bus1.VEC}, 32'hFFFC);
        nmi = 0;
        repeat (3) tick();
        RST = 1;
        pulse_ack();
        pulse_sync();
        check("async_nmi_lost", {31'b0, bus1.int_take}, 32'd0);

        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 4; k++) if ($urandom_range(0, 7) == 0) irq[k] = ~irq[k];
            if ($urandom_range(0, 5) == 0) nmi = ~nmi;
            if ($urandom_range(0, 3) == 0) i_flag = ~i_flag;
            sync    = ($urandom_range(0, 2) == 0);
            ack     = ($urandom_range(0, 3) == 0);
            mask_we = ($urandom_range(0, 15) == 0);
            mask_wd = 4'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #2 RST = 0;
                tick(); tick();
                RST = 1;
            end
            tick();
        end
        sync = 0; ack = 0; mask_we = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
